ignition_gear_controller: RTL and testbench

//  Parametrised successor to the top-level ignition FSM and gear register of the car simulator.
//  - Power-mode FSM: OFF/ACC/CRANK/RUN/STALL, with a timed crank phase, a debounced start key and fuel-stall handling.
//  - Gear selector with speed interlocks, brake shift-lock and a reject pulse.
//  - Drives engine_on/acc_on to vehicle logic, lights, steering, display and LCD.

---
 rtl/ignition_gear_controller.sv | 192 +++++++++++++++++++
 tb/tb_ignition_gear_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ignition_gear_controller.sv
// Ignition power-mode sequencer and gear selector for the car simulator.
// A tick-gated FSM handles key debounce, the timed crank phase and
// fuel stall. The gear register runs every CLK with speed interlocks
// and a brake shift-lock.
//
// state    | meaning
// S_OFF    | everything off
// S_ACC    | accessory power only
// S_CRANK  | starter engaged, counting crank ticks
// S_RUN    | engine running
// S_STALL  | engine died on empty fuel, accessory power kept
module ignition_gear_controller #(
   parameter int unsigned FUEL_W         = 8,
   parameter int unsigned SPD_W          = 8,
   parameter int unsigned FUEL_MIN       = 0,
   parameter int unsigned CRANK_TICKS    = 20,
   parameter int unsigned DEBOUNCE_TICKS = 3,
   parameter int unsigned PARK_MAX_SPD   = 0,
   parameter int unsigned REV_MAX_SPD    = 0,
   parameter bit          SHIFT_LOCK     = 1'b1
) (
   input  logic              CLK,
   input  logic              global_safe_rst,
   input  logic              tick,
   input  logic              key_start,
   input  logic              brake,
   input  logic              req_p,
   input  logic              req_r,
   input  logic              req_n,
   input  logic              req_d,
   input  logic [FUEL_W-1:0] fuel,
   input  logic [SPD_W-1:0]  speed,
   output logic [2:0]        power_state,
   output logic              engine_on,
   output logic              acc_on,
   output logic              crank_active,
   output logic [3:0]        gear,
   output logic              start_fail,
   output logic              shift_reject
);

   localparam int unsigned DW = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
   localparam int unsigned CW = $clog2(CRANK_TICKS + 1);

   localparam logic [DW-1:0]     DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
   localparam logic [DW-1:0]     DEB_MAX    = DW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0]     CRANK_LAST = CW'(CRANK_TICKS - 1);
   localparam logic [CW-1:0]     CRANK_MAX  = CW'(CRANK_TICKS);
   localparam logic [FUEL_W-1:0] FUEL_MIN_L = FUEL_W'(FUEL_MIN);
   localparam logic [SPD_W-1:0]  PARK_L     = SPD_W'(PARK_MAX_SPD);
   localparam logic [SPD_W-1:0]  REV_L      = SPD_W'(REV_MAX_SPD);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_ACC   = 3'd1,
      S_CRANK = 3'd2,
      S_RUN   = 3'd3,
      S_STALL = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      G_P = 4'd3,
      G_R = 4'd6,
      G_N = 4'd9,
      G_D = 4'd12
   } gear_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  crank_q, crank_d;
   logic [DW-1:0]  deb_cnt_q;
   logic           start_fail_q, start_fail_d;
   gear_t          gear_q, gear_d, target;
   logic [3:0]     req_q, req_now, req_edge;
   logic           shift_reject_q, shift_reject_d;
   logic           has_req, allowed;

   logic fuel_empty, start_ok, start_edge;

   assign fuel_empty = (fuel <= FUEL_MIN_L);
   assign start_ok   = brake & (gear_q == G_P) & ~fuel_empty;
   // The counter saturates at DEB_MAX, so the last step into it fires only once per hold.
   assign start_edge = tick & key_start & (deb_cnt_q == DEB_LAST);

   // Debounce counter: counts consecutive high ticks, cleared by any low tick.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         deb_cnt_q <= '0;
      end else if (tick) begin
         if (!key_start)
            deb_cnt_q <= '0;
         else if (deb_cnt_q != DEB_MAX)
            deb_cnt_q <= deb_cnt_q + 1'b1;
      end
   end

   // Power-mode state register, crank counter and start_fail pulse.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         state_q      <= S_OFF;
         crank_q      <= '0;
         start_fail_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         crank_q      <= crank_d;
         start_fail_q <= start_fail_d;
      end
   end

   // Power-mode next-state logic; advances only on tick.
   always_comb begin
      state_d      = state_q;
      crank_d      = (state_q == S_CRANK) ? crank_q : '0;
      start_fail_d = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_OFF: begin
               if (start_edge) state_d = start_ok ? S_CRANK : S_ACC;
            end
            S_ACC, S_STALL: begin
               if (start_edge) state_d = start_ok ? S_CRANK : S_OFF;
            end
            S_CRANK: begin
               if (crank_q != CRANK_MAX) crank_d = crank_q + 1'b1;
               if (fuel_empty || !brake) begin
                  state_d      = S_ACC;
                  start_fail_d = 1'b1;
               end else if (crank_q == CRANK_LAST) begin
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (fuel_empty)
                  state_d = S_STALL;
               else if (start_edge && (speed == '0))
                  state_d = S_OFF;
            end
            default: state_d = S_OFF;
         endcase
      end
   end

   assign req_now  = {req_d, req_n, req_r, req_p};
   assign req_edge = req_now & ~req_q;

   // Gear selection: only the highest-priority request edge is evaluated.
   always_comb begin
      gear_d         = gear_q;
      shift_reject_d = 1'b0;
      target         = gear_q;
      has_req        = 1'b1;
      allowed        = 1'b1;
      if (req_edge[0])      target = G_P;
      else if (req_edge[1]) target = G_R;
      else if (req_edge[2]) target = G_N;
      else if (req_edge[3]) target = G_D;
      else                  has_req = 1'b0;
      if (has_req && (target != gear_q)) begin
         if (SHIFT_LOCK && (gear_q == G_P) && !brake)
            allowed = 1'b0;
         else if (target == G_P)
            allowed = (speed <= PARK_L);
         else if (target == G_R)
            allowed = (speed <= REV_L);
         if (allowed)
            gear_d = target;
         else
            shift_reject_d = 1'b1;
      end
   end

   // Gear register, request edge detectors and reject pulse.
   always_ff @(posedge CLK or posedge global_safe_rst) begin
      if (global_safe_rst) begin
         gear_q         <= G_P;
         req_q          <= '0;
         shift_reject_q <= 1'b0;
      end else begin
         gear_q         <= gear_d;
         req_q          <= req_now;
         shift_reject_q <= shift_reject_d;
      end
   end

   assign power_state  = state_q;
   assign engine_on    = (state_q == S_RUN);
   assign acc_on       = (state_q != S_OFF);
   assign crank_active = (state_q == S_CRANK);
   assign gear         = gear_q;
   assign start_fail   = start_fail_q;
   assign shift_reject = shift_reject_q;

endmodule

// File: tb/tb_ignition_gear_controller.sv
// Bench for ignition_gear_controller: directed scenarios followed by
// random stimulus, all checked against a behavioural reference model.
module tb_ignition_gear_controller;

   localparam int FUEL_W = 8;
   localparam int SPD_W  = 8;
   localparam int FUEL_MIN = 0;
   localparam int CRANK_TICKS = 20;
   localparam int DEB = 3;
   localparam int PARK_MAX = 0;
   localparam int REV_MAX = 0;

   logic CLK = 1'b0;
   logic global_safe_rst = 1'b0;
   logic tick = 1'b0, key_start = 1'b0, brake = 1'b0;
   logic req_p = 1'b0, req_r = 1'b0, req_n = 1'b0, req_d = 1'b0;
   logic [FUEL_W-1:0] fuel = 8'd50;
   logic [SPD_W-1:0]  speed = 8'd0;
   logic [2:0] power_state;
   logic engine_on, acc_on, crank_active, start_fail, shift_reject;
   logic [3:0] gear;

   int vectors = 0;
   int miscompares = 0;

   // reference model state (power codes 0..4, legacy gear codes)
   int  m_state, m_gear, m_run, m_crank;
   bit  m_fail, m_rej;
   bit  m_prev[4];

   always #5 CLK = ~CLK;

   ignition_gear_controller #(
      .FUEL_W(FUEL_W), .SPD_W(SPD_W), .FUEL_MIN(FUEL_MIN),
      .CRANK_TICKS(CRANK_TICKS), .DEBOUNCE_TICKS(DEB),
      .PARK_MAX_SPD(PARK_MAX), .REV_MAX_SPD(REV_MAX), .SHIFT_LOCK(1'b1)
   ) dut (
      .CLK(CLK), .global_safe_rst(global_safe_rst), .tick(tick),
      .key_start(key_start), .brake(brake),
      .req_p(req_p), .req_r(req_r), .req_n(req_n), .req_d(req_d),
      .fuel(fuel), .speed(speed),
      .power_state(power_state), .engine_on(engine_on), .acc_on(acc_on),
      .crank_active(crank_active), .gear(gear),
      .start_fail(start_fail), .shift_reject(shift_reject)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_gear = 3; m_run = 0; m_crank = 0;
      m_fail = 0; m_rej = 0;
      foreach (m_prev[i]) m_prev[i] = 0;
   endtask

   // One CLK of the reference model, using the inputs present before the edge.
   task automatic model_clock();
      bit empty, st_edge, st_ok, ok;
      bit req[4];
      int codes[4] = '{3, 6, 9, 12};
      int sel;
      empty = (int'(fuel) <= FUEL_MIN);
      m_fail = 0;
      if (tick) begin
         st_edge = 0;
         if (key_start) begin
            m_run++;
            st_edge = (m_run == DEB);
         end else begin
            m_run = 0;
         end
         st_ok = brake && (m_gear == 3) && !empty;
         if (m_state == 0 || m_state == 1 || m_state == 4) begin
            if (st_edge) begin
               if (st_ok) begin m_state = 2; m_crank = 0; end
               else m_state = (m_state == 0) ? 1 : 0;
            end
         end else if (m_state == 2) begin
            if (empty || !brake) begin m_state = 1; m_fail = 1; end
            else if (m_crank == CRANK_TICKS - 1) m_state = 3;
            m_crank++;
         end else if (m_state == 3) begin
            if (empty) m_state = 4;
            else if (st_edge && speed == 0) m_state = 0;
         end
      end
      req[0] = req_p; req[1] = req_r; req[2] = req_n; req[3] = req_d;
      sel = -1;
      for (int i = 3; i >= 0; i--) if (req[i] && !m_prev[i]) sel = i;
      m_rej = 0;
      if (sel >= 0 && codes[sel] != m_gear) begin
         if (m_gear == 3 && !brake) ok = 0;
         else if (sel == 0) ok = (int'(speed) <= PARK_MAX);
         else if (sel == 1) ok = (int'(speed) <= REV_MAX);
         else ok = 1;
         if (ok) m_gear = codes[sel];
         else m_rej = 1;
      end
      for (int i = 0; i < 4; i++) m_prev[i] = req[i];
   endtask

   task automatic check_model();
      check("power_state", 32'(power_state), 32'(m_state));
      check("engine_on", 32'(engine_on), 32'(m_state == 3));
      check("acc_on", 32'(acc_on), 32'(m_state != 0));
      check("crank_active", 32'(crank_active), 32'(m_state == 2));
      check("gear", 32'(gear), 32'(m_gear));
      check("start_fail", 32'(start_fail), 32'(m_fail));
      check("shift_reject", 32'(shift_reject), 32'(m_rej));
   endtask

   task automatic clk_step();
      model_clock();
      @(posedge CLK);
      #1;
      check_model();
   endtask

   task automatic do_tick(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; clk_step();
         tick = 1'b0; clk_step();
      end
   endtask

   task automatic pulse_req(input int which);
      req_p = (which == 0); req_r = (which == 1);
      req_n = (which == 2); req_d = (which == 3);
      clk_step();
      req_p = 0; req_r = 0; req_n = 0; req_d = 0;
      clk_step();
   endtask

   task automatic apply_reset();
      #2 global_safe_rst = 1'b1;
      #1;
      check("rst_state", 32'(power_state), 32'd0);
      check("rst_gear", 32'(gear), 32'd3);
      check("rst_pulses", 32'({start_fail, shift_reject, engine_on, acc_on}), 32'd0);
      @(posedge CLK); #1;
      global_safe_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      model_reset();
      @(posedge CLK); #1;
      apply_reset();

      // Key high 2, low 1, high 2: never reaches a valid press
      key_start = 1; do_tick(2);
      key_start = 0; do_tick(1);
      key_start = 1; do_tick(2);
      key_start = 0; do_tick(1);
      check("s2_off", 32'(power_state), 32'd0);

      // Clean start: CRANK on tick 3, RUN 20 ticks later
      brake = 1; fuel = 8'd50;
      key_start = 1; do_tick(3);
      check("s1_crank", 32'(power_state), 32'd2);
      key_start = 0; do_tick(19);
      check("s1_still_crank", 32'(power_state), 32'd2);
      do_tick(1);
      check("s1_run", 32'(power_state), 32'd3);
      check("s1_engine_on", 32'(engine_on), 32'd1);

      // Fuel stall, refuel alone does not restart, key restarts
      fuel = 8'd0; do_tick(1);
      check("s4_stall", 32'(power_state), 32'd4);
      fuel = 8'd80; do_tick(3);
      check("s4_stays_stall", 32'(power_state), 32'd4);
      key_start = 1; do_tick(3);
      check("s4_crank", 32'(power_state), 32'd2);
      key_start = 0; do_tick(9);

      // Brake released at crank tick 10
      brake = 0; tick = 1; clk_step();
      check("s3_acc", 32'(power_state), 32'd1);
      check("s3_fail_pulse", 32'(start_fail), 32'd1);
      tick = 0; clk_step();
      check("s3_fail_clear", 32'(start_fail), 32'd0);
      check("s3_engine_off", 32'(engine_on), 32'd0);

      // Restart from ACC and shift to D
      brake = 1; key_start = 1; do_tick(3);
      key_start = 0; do_tick(20);
      check("run_again", 32'(power_state), 32'd3);
      pulse_req(3);
      check("gear_d", 32'(gear), 32'd12);

      // Moving: key ignored, reverse refused
      speed = 8'd30; key_start = 1; do_tick(3);
      key_start = 0; do_tick(1);
      check("s5_key_ignored", 32'(power_state), 32'd3);
      req_r = 1; clk_step();
      check("s5_reject", 32'(shift_reject), 32'd1);
      check("s5_gear_kept", 32'(gear), 32'd12);
      req_r = 0; clk_step();
      check("s5_reject_clear", 32'(shift_reject), 32'd0);
      speed = 8'd0; pulse_req(1);
      check("s5_gear_r", 32'(gear), 32'd6);
      key_start = 1; do_tick(3);
      key_start = 0; do_tick(1);
      check("s5_off", 32'(power_state), 32'd0);

      // Shift lock and simultaneous requests
      pulse_req(0);
      check("s6_gear_p", 32'(gear), 32'd3);
      brake = 0; req_d = 1; clk_step();
      check("s6_lock_reject", 32'(shift_reject), 32'd1);
      check("s6_lock_gear", 32'(gear), 32'd3);
      req_d = 0; clk_step();
      brake = 1; pulse_req(3);
      check("s6_gear_d", 32'(gear), 32'd12);
      req_p = 1; req_d = 1; clk_step();
      check("s6_simul_p", 32'(gear), 32'd3);
      req_p = 0; req_d = 0; clk_step();
      pulse_req(2);
      check("s6_gear_n", 32'(gear), 32'd9);
      speed = 8'd30; req_p = 1; req_n = 1; clk_step();
      check("p_refused_gear", 32'(gear), 32'd9);
      check("p_refused_rej", 32'(shift_reject), 32'd1);
      req_p = 0; req_n = 0; speed = 0; clk_step();

      // Random stimulus
      for (int k = 0; k < 1200; k++) begin
         if (k == 600) begin
            apply_reset();
            continue;
         end
         tick = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 5) == 0) key_start = ~key_start;
         if ($urandom_range(0, 12) == 0) brake = ~brake;
         if ($urandom_range(0, 9) == 0) req_p = ~req_p;
         if ($urandom_range(0, 9) == 0) req_r = ~req_r;
         if ($urandom_range(0, 9) == 0) req_n = ~req_n;
         if ($urandom_range(0, 9) == 0) req_d = ~req_d;
         if ($urandom_range(0, 40) == 0)
            case ($urandom_range(0, 3))
               0: fuel = 8'd0;
               1: fuel = 8'd1;
               2: fuel = 8'd50;
               default: fuel = 8'd255;
            endcase
         if ($urandom_range(0, 15) == 0)
            case ($urandom_range(0, 3))
               0, 1: speed = 8'd0;
               2: speed = 8'd1;
               default: speed = 8'($urandom_range(2, 255));
            endcase
         clk_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
